// File: rtl/nios_send_rx_pkg.sv
// nios_send_pkg: status word field positions and DEPTH legality check shared by the Nios send receiver.
package nios_send_pkg;
   localparam int ST_DROP_LSB = 24;
   localparam int ST_ADDR_LSB = 16;
   localparam int ST_ACC_LSB  = 8;
   localparam int ST_OVF_BIT  = 4;
   localparam int ST_LVL_LSB  = 0;

   function automatic bit depth_ok(input int d);
      return (d == 2) || (d == 4) || (d == 8);
   endfunction
endpackage

// File: rtl/nios_send_rx_fifo.sv
// nios_send_fifo: synchronous first-word fall-through FIFO with push, pop, full, empty and level.
module nios_send_fifo #(
   parameter int W     = 40,
   parameter int DEPTH = 4
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic [W-1:0]               i_din,
   input  logic                       i_pop,
   output logic [W-1:0]               o_dout,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [LW-1:0] r_level;
   logic          w_push;
   logic          w_pop;

   assign o_full  = r_level == LW'(DEPTH);
   assign o_empty = r_level == '0;
   assign o_level = r_level;
   assign o_dout  = r_mem[r_rd];
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);

   // Storage, pointers wrapping modulo DEPTH, and level; reset discards every entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_din;
            r_wr        <= r_wr + PW'(1);
         end
         if (w_pop) r_rd <= r_rd + PW'(1);
         r_level <= r_level + LW'(w_push) - LW'(w_pop);
      end
   end
endmodule

// File: rtl/nios_send_rx.sv
// nios_send_rx: turns Nios ack-toggle sends into a FIFO-buffered packet stream with a status word.
// Define NIOS_SEND_RX_DROPCNT_EN to enable the saturating drop counter and overflow sticky bit.
module nios_send_rx
   import nios_send_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] send_addr,
   input  logic [DATA_W-1:0] send_data,
   input  logic              ack_in,
   output logic              pkt_valid,
   input  logic              pkt_ready,
   output logic [ADDR_W-1:0] pkt_addr,
   output logic [DATA_W-1:0] pkt_data,
   output logic [31:0]       status_out
);
   localparam int LW = $clog2(DEPTH) + 1;
   localparam int W  = ADDR_W + DATA_W;

   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("nios_send_rx: DEPTH must be 2, 4 or 8");
   end

   logic          r_ack_prev;
   logic [31:0]   r_status;
   logic [31:0]   w_status_nxt;
   logic          w_event;
   logic          w_pop;
   logic          w_push;
   logic          w_full;
   logic          w_empty;
   logic [LW-1:0] w_level;
   logic [LW-1:0] w_level_nxt;
   logic [W-1:0]  w_head;
   logic [7:0]    w_addr8;

   assign w_event     = !reset && (ack_in != r_ack_prev);
   assign pkt_valid   = !reset && !w_empty;
   assign w_pop       = pkt_valid && pkt_ready;
   assign w_push      = w_event && (!w_full || w_pop);
   assign w_level_nxt = w_level + LW'(w_push) - LW'(w_pop);
   assign w_addr8     = 8'(send_addr);
   assign {pkt_addr, pkt_data} = reset ? '0 : w_head;
   assign status_out  = reset ? '0 : r_status;

`ifdef NIOS_SEND_RX_DROPCNT_EN
   logic w_drop;
   assign w_drop = w_event && w_full && !w_pop;
`endif

   nios_send_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_din   ({send_addr, send_data}),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   // Next status word reflects the state after this cycle's push/pop/drop.
   always_comb begin
      w_status_nxt = '0;
      w_status_nxt[ST_ADDR_LSB +: 8] = w_push ? w_addr8 : r_status[ST_ADDR_LSB +: 8];
      w_status_nxt[ST_ACC_LSB +: 8]  = r_status[ST_ACC_LSB +: 8] + 8'(w_push);
      w_status_nxt[ST_LVL_LSB +: 4]  = 4'(w_level_nxt);
`ifdef NIOS_SEND_RX_DROPCNT_EN
      w_status_nxt[ST_DROP_LSB +: 8] = r_status[ST_DROP_LSB +: 8] + 8'(w_drop && r_status[ST_DROP_LSB +: 8] != 8'hFF);
      w_status_nxt[ST_OVF_BIT]       = r_status[ST_OVF_BIT] | w_drop;
`endif
   end

   // Ack history tracks ack_in even in reset, so a held level never looks like a send.
   always_ff @(posedge clk) begin
      r_ack_prev <= ack_in;
      r_status   <= reset ? '0 : w_status_nxt;
   end
endmodule

// File: tb/tb_nios_send_rx.sv
// tb_nios_send_rx: directed self-checking bench for nios_send_rx (DEPTH=4), either NIOS_SEND_RX_DROPCNT_EN build.
module tb_nios_send_rx;
   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  send_addr;
   logic [31:0] send_data;
   logic        ack_in;
   logic        pkt_valid;
   logic        pkt_ready;
   logic [7:0]  pkt_addr;
   logic [31:0] pkt_data;
   logic [31:0] status_out;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   nios_send_rx #(.ADDR_W(8), .DATA_W(32), .DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .send_addr  (send_addr),
      .send_data  (send_data),
      .ack_in     (ack_in),
      .pkt_valid  (pkt_valid),
      .pkt_ready  (pkt_ready),
      .pkt_addr   (pkt_addr),
      .pkt_data   (pkt_data),
      .status_out (status_out)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic toggle(input logic [7:0] a, input logic [31:0] d);
      send_addr = a;
      send_data = d;
      ack_in    = ~ack_in;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; ack_in = 1'b1; send_addr = '0; send_data = '0; pkt_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", pkt_valid, 0);
      chk("rst_status", status_out, 0);
      chk("rst_data", pkt_data, 0);
      // Release with ack_in held high: no event.
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("hold_valid", pkt_valid, 0);
      chk("hold_status", status_out, 0);
      // Ready while empty does nothing.
      pkt_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("empty_ready_valid", pkt_valid, 0);
      chk("empty_ready_status", status_out, 0);
      // Re-enter reset with ack low so the first send is a 0->1 toggle.
      reset = 1'b1; ack_in = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("low_hold_valid", pkt_valid, 0);
      // Single send, popped immediately.
      toggle(8'h12, 32'hDEADBEEF);
      chk("one_valid", pkt_valid, 1);
      chk("one_addr", pkt_addr, 8'h12);
      chk("one_data", pkt_data, 32'hDEADBEEF);
      chk("one_status", status_out, 32'h0012_0101);
      @(negedge clk);
      chk("one_popped", pkt_valid, 0);
      chk("one_status_after", status_out, 32'h0012_0100);
      // Six sends into a 4-deep FIFO with no consumer.
      pkt_ready = 1'b0;
      for (int i = 0; i < 6; i++) toggle(8'h20 + 8'(i), 32'hA0 + 32'(i));
      chk("ovf_valid", pkt_valid, 1);
      chk("ovf_addr", pkt_addr, 8'h20);
      chk("ovf_data", pkt_data, 32'hA0);
`ifdef NIOS_SEND_RX_DROPCNT_EN
      chk("ovf_status", status_out, 32'h0223_0514);
`else
      chk("ovf_status", status_out, 32'h0023_0504);
`endif
      @(negedge clk);
      chk("ovf_stable_addr", pkt_addr, 8'h20);
      chk("ovf_stable_data", pkt_data, 32'hA0);
      // Full FIFO, send and pop in the same cycle.
      pkt_ready = 1'b1;
      toggle(8'h30, 32'hB0);
      pkt_ready = 1'b0;
      chk("fullpp_addr", pkt_addr, 8'h21);
`ifdef NIOS_SEND_RX_DROPCNT_EN
      chk("fullpp_status", status_out, 32'h0230_0614);
`else
      chk("fullpp_status", status_out, 32'h0030_0604);
`endif
      // Drain and check order.
      pkt_ready = 1'b1;
      chk("drain0", pkt_addr, 8'h21);
      @(negedge clk);
      chk("drain1", pkt_addr, 8'h22);
      @(negedge clk);
      chk("drain2", pkt_addr, 8'h23);
      @(negedge clk);
      chk("drain3_addr", pkt_addr, 8'h30);
      chk("drain3_data", pkt_data, 32'hB0);
      @(negedge clk);
      chk("drain_empty", pkt_valid, 0);
`ifdef NIOS_SEND_RX_DROPCNT_EN
      chk("drain_status", status_out, 32'h0230_0600);
`else
      chk("drain_status", status_out, 32'h0030_0600);
`endif
      // Fill, then 300 dropped sends.
      pkt_ready = 1'b0;
      for (int i = 0; i < 4; i++) toggle(8'h40 + 8'(i), 32'hC0 + 32'(i));
      for (int i = 0; i < 300; i++) toggle(8'h55, 32'h5555);
`ifdef NIOS_SEND_RX_DROPCNT_EN
      chk("sat_drop", status_out[31:24], 8'hFF);
      chk("sat_ovf", status_out[4], 1);
      chk("sat_status", status_out, 32'hFF43_0A14);
`else
      chk("sat_drop", status_out[31:24], 8'h00);
      chk("sat_ovf", status_out[4], 0);
      chk("sat_status", status_out, 32'h0043_0A04);
`endif
      chk("sat_head", pkt_addr, 8'h40);
      // Pop one to leave three queued, then reset.
      pkt_ready = 1'b1;
      @(negedge clk);
      pkt_ready = 1'b0;
      chk("three_level", status_out[3:0], 4'd3);
      chk("three_head", pkt_addr, 8'h41);
      reset = 1'b1;
      #1;
      chk("inrst_valid", pkt_valid, 0);
      chk("inrst_addr", pkt_addr, 0);
      chk("inrst_status", status_out, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("postrst_valid", pkt_valid, 0);
      chk("postrst_status", status_out, 0);
      @(negedge clk);
      chk("noreplay_valid", pkt_valid, 0);
      chk("noreplay_status", status_out, 0);
      toggle(8'h77, 32'h1234_5678);
      chk("new_valid", pkt_valid, 1);
      chk("new_addr", pkt_addr, 8'h77);
      chk("new_data", pkt_data, 32'h1234_5678);
      chk("new_status", status_out, 32'h0077_0101);
      pkt_ready = 1'b1;
      @(negedge clk);
      chk("new_popped", pkt_valid, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/nios_send_rx.md
NIOS_SEND_RX -- requirements
Module: nios_send_rx

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address width of a Nios send.
REQ-002 SHALL have parameter DATA_W, default 32, data width of a Nios send.
REQ-003 SHALL have parameter DEPTH, default 4, number of FIFO entries; legal values are powers of two from 2 to 8.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port send_addr, input, ADDR_W bits: address written by the Nios send-address PIO.
REQ-007 SHALL have port send_data, input, DATA_W bits: data written by the Nios send-data PIO.
REQ-008 SHALL have port ack_in, input, 1 bit: Nios ack PIO; every toggle marks one new send.
REQ-009 SHALL have port pkt_valid, output, 1 bit: a packet is available downstream.
REQ-010 SHALL have port pkt_ready, input, 1 bit: downstream accepts the packet.
REQ-011 SHALL have port pkt_addr, output, ADDR_W bits: address of the head packet.
REQ-012 SHALL have port pkt_data, output, DATA_W bits: data of the head packet.
REQ-013 SHALL have port status_out, output, 32 bits: status word returned to the Nios 32-bit read PIO.

Function
REQ-014 SHALL detect a send event in any cycle where ack_in differs from registered ack_prev; both edges count, and ack_prev updates every cycle.
REQ-015 SHALL capture {send_addr, send_data} in the event cycle, with no additional synchronisation, since the Nios sets addr/data before toggling ack.
REQ-016 SHALL push the captured pair into the FIFO on an event when the FIFO is not full; the entry becomes visible on pkt_* on the next cycle.
REQ-017 SHALL drop an event arriving when the FIFO is full with no pop in that cycle; FIFO contents stay unchanged.
REQ-018 SHALL accept the push when the FIFO is full and a pop occurs in the same cycle; the level stays at DEPTH.
REQ-019 SHALL, when an event and a pop occur together at any other level, perform both; the level is unchanged.
REQ-020 SHALL present the FIFO head as first-word fall-through: pkt_valid is high while level>0, and pkt_addr/pkt_data are stable while pkt_valid is high and pkt_ready is low.
REQ-021 SHALL pop only on pkt_valid && pkt_ready; pkt_ready while empty has no effect.
REQ-022 SHALL use read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH, plus a level counter of log2(DEPTH)+1 bits.
REQ-023 SHALL lay out status_out, registered and updated one cycle after the causing event, as:
- [31:24] drop count
- [23:16] last accepted address (zero-extended/truncated to 8)
- [15:8] accepted-send count, mod 256, wraps
- [7:5] zero
- [4] overflow sticky
- [3:0] FIFO level

Reset
REQ-024 SHALL, while reset is high, clear the FIFO, both pointers, the level, all counters, and the sticky overflow bit.
REQ-025 SHALL force pkt_valid=0, pkt_addr=0, pkt_data=0 and status_out=0 during reset.
REQ-026 SHALL load ack_prev from ack_in every cycle of reset, so an ack_in level held across reset release produces no event.
REQ-027 SHALL, when reset asserts mid-transfer, discard all pending entries; after reset nothing already captured is replayed.

Configuration
REQ-028 SHALL, with NIOS_SEND_RX_DROPCNT_EN defined, increment a saturating 8-bit drop counter (holds at 255) on every dropped event and set overflow sticky, cleared only by reset.
REQ-029 SHALL, without NIOS_SEND_RX_DROPCNT_EN, omit the counter and sticky logic and tie status_out[31:24] and [4] to zero; drops still occur per REQ-017.

Structure
REQ-030 SHALL place the status bit-field position constants and the DEPTH legality check in shared package nios_send_pkg.
REQ-031 SHALL implement the storage as one sub-module, nios_send_fifo (a synchronous FIFO with push, pop, full, empty and level); the event detect and status logic stay in the top level.

Verification
REQ-032 SHALL cover reset with ack_in=1 held, released, then no toggle: pkt_valid stays 0 and status_out stays 0.
REQ-033 SHALL cover addr=0x12, data=0xDEADBEEF, ack toggled 0->1 with pkt_ready=1: pkt_valid=1 next cycle with 0x12/0xDEADBEEF, popped, and status [23:16]=0x12, [15:8]=1.
REQ-034 SHALL cover 6 toggles with pkt_ready=0 and DEPTH=4: level=4, drops=2, overflow=1, and pkt_* shows the first send unchanged.
REQ-035 SHALL cover the FIFO full, with a toggle and pkt_ready=1 in the same cycle: the new entry is accepted, level stays 4, and the drop count is unchanged.
REQ-036 SHALL cover 300 drops with the macro defined: drop count=255; with the macro undefined, [31:24]=0 and [4]=0.
REQ-037 SHALL cover reset asserted with 3 entries queued: next cycle level=0 and pkt_valid=0, and a subsequent toggle delivers only the new pair.
